// File: rtl/dtm_agg_pkg.sv
// Shared definitions for the DTM receive-lane aggregator.
package dtm_agg_pkg;

  // Default lane word width.
  localparam int unsigned DefaultDataW = 10;

  // Width of a channel tag: clog2 of the lane count, never below one bit.
  function automatic int unsigned ch_tag_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtm_agg_fifo.sv
// Single-lane synchronous FIFO with a combinational head word.
// Pointers carry one extra wrap bit to tell full from empty.
module dtm_agg_fifo #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dtm_rx_aggregator.sv
// Merges NUM_CH COB receive lanes into one tagged valid/ready stream.
// Per-lane FIFOs, round-robin arbitration, registered output, sticky drop flags.
// Optional build macro DTM_AGG_STATS_EN adds per-lane saturating word counters.
module dtm_rx_aggregator
  import dtm_agg_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CH_W      = ch_tag_w(NUM_CH)
) (
  input  logic                     distClk,
  input  logic                     distClkRst,
  input  logic [NUM_CH-1:0]        chEnable,
  input  logic [NUM_CH*DATA_W-1:0] rxData,
  input  logic [NUM_CH-1:0]        rxDataEn,
  output logic [DATA_W-1:0]        txData,
  output logic [CH_W-1:0]          txChan,
  output logic                     txDataEn,
  input  logic                     txReady,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     overflowClr,
`ifdef DTM_AGG_STATS_EN
  output logic [NUM_CH*16-1:0]     wordCount,
`endif
  output logic [NUM_CH-1:0]        fifoEmpty
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] wr_req, accept, drop, pop;
  logic [NUM_CH-1:0] lane_full, lane_empty;
  logic [DATA_W-1:0] lane_head  [NUM_CH];
  logic [CntW-1:0]   lane_count [NUM_CH];

  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CH_W-1:0]   tx_chan_q, tx_chan_d;
  logic              tx_valid_q, tx_valid_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] overflow_q, overflow_d;

  logic              load_slot;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  int unsigned       cand;
  logic [CH_W-1:0]   cand_idx;

  assign load_slot = !tx_valid_q || txReady;
  assign wr_req    = rxDataEn & chEnable;
  // Popping a lane frees a slot for a same-cycle write to that lane.
  assign accept    = wr_req & (~lane_full | pop);
  assign drop      = wr_req & ~accept;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    dtm_agg_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (distClk),
      .rst_i   (distClkRst),
      .push_i  (accept[k]),
      .pop_i   (pop[k]),
      .data_i  (rxData[k*DATA_W +: DATA_W]),
      .data_o  (lane_head[k]),
      .full_o  (lane_full[k]),
      .empty_o (lane_empty[k]),
      .count_o (lane_count[k])
    );
  end

  // Round-robin search: first non-empty lane starting at ptr_q.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = CH_W'(cand);
      if (!grant_found && (lane_count[cand_idx] != '0)) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Pop the granted lane only when the output register can take its word.
  always_comb begin
    pop = '0;
    if (load_slot && grant_found) pop[grant_idx] = 1'b1;
  end

  // Output register, arbitration pointer and overflow flag next-state.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_chan_d  = tx_chan_q;
    ptr_d      = ptr_q;
    if (load_slot) begin
      tx_valid_d = grant_found;
      if (grant_found) begin
        tx_data_d = lane_head[grant_idx];
        tx_chan_d = grant_idx;
        ptr_d     = (32'(grant_idx) + 1 >= NUM_CH) ? '0 : grant_idx + 1'b1;
      end
    end
    // Clear wins over a concurrent drop; that drop is not recorded.
    overflow_d = overflowClr ? '0 : (overflow_q | drop);
  end

  // State registers with synchronous reset.
  always_ff @(posedge distClk) begin
    if (distClkRst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_chan_q  <= '0;
      ptr_q      <= '0;
      overflow_q <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_chan_q  <= tx_chan_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign txData    = tx_data_q;
  assign txChan    = tx_chan_q;
  assign txDataEn  = tx_valid_q;
  assign overflow  = overflow_q;
  assign fifoEmpty = lane_empty;

`ifdef DTM_AGG_STATS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_stats
    logic [15:0] word_cnt_q, word_cnt_d;

    // Saturating count of accepted writes; overflowClr also clears it.
    always_comb begin
      word_cnt_d = word_cnt_q;
      if (overflowClr) begin
        word_cnt_d = '0;
      end else if (accept[k] && (word_cnt_q != 16'hFFFF)) begin
        word_cnt_d = word_cnt_q + 16'd1;
      end
    end

    // Counter register.
    always_ff @(posedge distClk) begin
      if (distClkRst) word_cnt_q <= '0;
      else            word_cnt_q <= word_cnt_d;
    end

    assign wordCount[k*16 +: 16] = word_cnt_q;
  end
`endif

endmodule

// File: doc/dtm_rx_aggregator.md
Name: dtm_rx_aggregator

Overview:
Parametrised successor to the DTM COB timing interface. It merges NUM_CH COB receive lanes (DATA_W-bit words with enable strobes) into one transmit stream toward the RTM/backplane. Each lane has a small per-channel FIFO. Lanes are served by a round-robin arbiter, and the output uses a valid/ready handshake with channel tagging and sticky overflow flags. It sits in the DTM distClk domain, between the rxData* lanes and the txDataA/B ports.

Parameters:
NUM_CH, 8, number of receive lanes (1..16)
DATA_W, 10, word width per lane
FIFO_DEPTH, 4, words per lane FIFO; power of two, >=2
CH_W, $clog2(NUM_CH) (min 1), width of channel tag (derived, localparam)

Ports:
distClk  in  1  clock; all logic on rising edge
distClkRst  in  1  synchronous active-high reset
chEnable  in  NUM_CH  per-lane enable; disabled lanes ignore rxDataEn
rxData  in  NUM_CH*DATA_W  lane words; lane k at [k*DATA_W +: DATA_W]
rxDataEn  in  NUM_CH  per-lane word strobe, one word per high cycle
txData  out  DATA_W  output word
txChan  out  CH_W  source lane of txData
txDataEn  out  1  output valid
txReady  in  1  downstream accept
overflow  out  NUM_CH  sticky per-lane drop flag
overflowClr  in  1  clears all overflow bits
fifoEmpty  out  NUM_CH  per-lane FIFO empty status

Behaviour:
- Interface: one clock, distClk. Reset distClkRst is synchronous, active-high.
- Reset values: txDataEn=0, txData=0, txChan=0, overflow=0, fifoEmpty=all 1. All FIFOs are flushed and the round-robin pointer is set to 0. A reset mid-transfer discards any held word; no handshake completes in the reset cycle.
- Lane write: a word is pushed when rxDataEn[k] && chEnable[k] && (count_k < FIFO_DEPTH, or lane k is popped in the same cycle).
  - Otherwise the word is dropped and overflow[k] is set on the next edge.
- Overflow flags: overflowClr has priority over a concurrent set, and the simultaneous new drop is lost.
- FIFO pointers: clog2(FIFO_DEPTH)+1 bits with wrap.
  - Empty: pointers equal.
  - Full: MSBs differ and the rest are equal.
- Output register: txData, txChan and txDataEn are registered. The register loads when !txDataEn || txReady (load slot).
- Arbitration in a load slot:
  - Search lanes from ptr, ptr+1, … mod NUM_CH and take the first non-empty lane g.
  - Pop g, load its head word, set txChan=g and txDataEn=1, and set ptr=(g+1) mod NUM_CH.
  - If no lane is non-empty, txDataEn goes to 0 (only in a load slot).
- Handshake: a transfer occurs on a cycle where txDataEn && txReady. While txDataEn=1 && !txReady, txData and txChan are held stable.
- Throughput and latency: one word per cycle with txReady tied high. Latency is 2 cycles: a word strobed in cycle t appears with txDataEn=1 in cycle t+2 when its lane wins.
- Disabling a lane: dropping chEnable[k] stops writes only. Words already queued still drain.
- Ordering: order within a lane is preserved. There is no ordering guarantee across lanes.

Optional Feature:
DTM_AGG_STATS_EN
- Defined: adds output wordCount [NUM_CH*16], one 16-bit saturating counter per lane.
  - Increments on each accepted write. It holds at 0xFFFF.
  - Cleared by reset and by overflowClr.
- Undefined: the port and counters are absent. Remaining behaviour is identical.

Decomposition:
- Package dtm_agg_pkg: DATA_W default and the channel-tag width function (clog2 with min 1).
- Sub-module dtm_agg_fifo: single-lane synchronous FIFO with push, pop, full, empty and count ports. The top instantiates it in a generate loop and holds the arbiter and output register.

Test Plan:
1. Reset then idle: txDataEn=0, overflow=0, fifoEmpty=8'hFF. Send rxDataEn[3] with 10'h155 at t → at t+2, txDataEn=1, txData=10'h155, txChan=3.
2. Lanes 0, 2, 5 each strobe one word in the same cycle, txReady=1 → outputs on three consecutive cycles in lane order 0, 2, 5. With ptr starting at 3, the order is 5, 0, 2.
3. Backpressure: txReady=0 for 10 cycles while lane 1 receives 6 words (DEPTH=4) → txData holds the first word. overflow[1]=1 after the 6th strobe. After release, 5 words exit: 1 from the register and 4 from the FIFO.
4. Full FIFO with simultaneous pop and push on lane 0 → word accepted, no overflow. Pulse overflowClr in the same cycle as a new drop → overflow[0]=0.
5. Reset asserted while txDataEn=1 and FIFOs are non-empty → next cycle: txDataEn=0, all fifoEmpty=1, no stale words afterwards.
6. chEnable[4]=0 with a strobe on lane 4 → nothing is queued and no overflow. With DTM_AGG_STATS_EN, send 0x10000 strobes on lane 7 → wordCount[7] saturates at 0xFFFF.
